// File: rtl/mem_responder.sv
// mem_responder: wait-state memory responder for the suro-v.2 memory port.
// Accepts rden/wren strobes, delays by WAIT_CYCLES, accesses a word SRAM.
module mem_responder #(
    parameter int    DEPTH_WORDS = 4096,
    parameter int    WAIT_CYCLES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rden,
    input  logic        mem_wren,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        done,
    output logic        fault
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;

    logic          rd_q;
    logic          wr_q;
    logic          fault_q;
    logic [31:0]   addr_q;
    logic [1:0]    size_q;
    logic [31:0]   wdata_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          req_fault;
    logic          go_resp;

    logic          cur_rd;
    logic          cur_wr;
    logic          cur_fault;
    logic [31:0]   cur_addr;
    logic [1:0]    cur_size;
    logic [31:0]   cur_wdata;

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [3:0]    be;
    logic [31:0]   wshift;
    logic [31:0]   rword;
    logic [31:0]   rmasked;
    logic [31:0]   rd_val;

    assign accept = (state != S_WAIT) && (mem_rden || mem_wren);

    always_comb begin
        req_fault = 1'b0;
        if (mem_rden && mem_wren)
            req_fault = 1'b1;
        if (mem_size == 2'd3)
            req_fault = 1'b1;
        if (mem_size == SZ_HALF && mem_addr[0])
            req_fault = 1'b1;
        if (mem_size == SZ_WORD && mem_addr[1:0] != 2'b00)
            req_fault = 1'b1;
        if ({2'b00, mem_addr[31:2]} >= 32'(DEPTH_WORDS))
            req_fault = 1'b1;
    end

    // With zero wait states the access is performed on the acceptance
    // edge itself, so the live request is used instead of the latched one.
    always_comb begin
        cur_rd    = rd_q;
        cur_wr    = wr_q;
        cur_fault = fault_q;
        cur_addr  = addr_q;
        cur_size  = size_q;
        cur_wdata = wdata_q;
        if (accept) begin
            cur_rd    = mem_rden;
            cur_wr    = mem_wren;
            cur_fault = req_fault;
            cur_addr  = mem_addr;
            cur_size  = mem_size;
            cur_wdata = mem_wdata;
        end
    end

    always_comb begin
        go_resp = 1'b0;
        if (accept)
            go_resp = (WAIT_CYCLES == 0);
        else if (state == S_WAIT && cnt == '0)
            go_resp = 1'b1;
    end

    assign idx    = cur_addr[AW+1:2];
    assign lane   = cur_addr[1:0];
    assign wshift = cur_wdata << {lane, 3'b000};
    assign rword  = mem[idx] >> {lane, 3'b000};

    always_comb begin
        be      = 4'b0000;
        rmasked = 32'h0;
        unique case (cur_size)
            SZ_BYTE: begin
                be      = 4'b0001 << lane;
                rmasked = {24'h0, rword[7:0]};
            end
            SZ_HALF: begin
                be      = 4'b0011 << lane;
                rmasked = {16'h0, rword[15:0]};
            end
            SZ_WORD: begin
                be      = 4'b1111;
                rmasked = rword;
            end
            default: begin
                be      = 4'b0000;
                rmasked = 32'h0;
            end
        endcase
    end

    assign rd_val = (cur_rd && !cur_fault) ? rmasked : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            done      <= 1'b0;
            fault     <= 1'b0;
            mem_rdata <= 32'h0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            fault_q   <= 1'b0;
            addr_q    <= 32'h0;
            size_q    <= 2'b00;
            wdata_q   <= 32'h0;
        end else begin
            done <= go_resp;
            if (go_resp) begin
                mem_rdata <= rd_val;
                fault     <= cur_fault;
            end
            if (accept) begin
                rd_q    <= mem_rden;
                wr_q    <= mem_wren;
                fault_q <= req_fault;
                addr_q  <= mem_addr;
                size_q  <= mem_size;
                wdata_q <= mem_wdata;
                if (WAIT_CYCLES == 0) begin
                    state <= S_RESP;
                    cnt   <= '0;
                end else begin
                    state <= S_WAIT;
                    cnt   <= CW'(WAIT_CYCLES - 1);
                end
            end else begin
                unique case (state)
                    S_WAIT: begin
                        if (cnt == '0)
                            state <= S_RESP;
                        else
                            cnt <= cnt - 1'b1;
                    end
                    S_RESP:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // A write lands only on the edge entering RESP; reset on that edge drops it.
    always_ff @(posedge clk) begin
        if (!rst && go_resp && cur_wr && !cur_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[idx][8*i +: 8] <= wshift[8*i +: 8];
            end
        end
    end

endmodule
